// File: rtl/seq_detect_param_if.sv
// Stream/config bundle for the parametrised sequence detector.
// The master drives configuration and the symbol stream; the slave is the detector.
interface seq_detect_param_if #(
    parameter int DW  = 8,
    parameter int LEN = 3,
    parameter int CW  = 16
);
    logic              cfg_load;
    logic [DW*LEN-1:0] pat_i;
    logic              ovl_i;
    logic              valid_i;
    logic [DW-1:0]     data_i;
    logic              cnt_clr;
    logic              armed_o;
    logic              flag_o;
    logic [CW-1:0]     cnt_o;

    modport master (
        output cfg_load, pat_i, ovl_i, valid_i, data_i, cnt_clr,
        input  armed_o, flag_o, cnt_o
    );

    modport slave (
        input  cfg_load, pat_i, ovl_i, valid_i, data_i, cnt_clr,
        output armed_o, flag_o, cnt_o
    );
endinterface

// File: rtl/seq_detect_param.sv
// Streaming LEN-symbol sequence detector with a runtime-loadable pattern,
// selectable overlap mode, valid-qualified input and a saturating match counter.
// The last LEN-1 accepted symbols are kept oldest-first in hist_reg[0..LEN-2];
// a match compares that history plus the incoming symbol against the pattern.
module seq_detect_param #(
    parameter int DW  = 8,
    parameter int LEN = 3,
    parameter int CW  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    seq_detect_param_if.slave  bus
);
    localparam int            FW       = $clog2(LEN);
    localparam logic [FW-1:0] FILL_MAX = FW'(LEN - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_reg;
    logic [DW*LEN-1:0] pat_reg;
    logic              ovl_reg;
    logic [DW-1:0]     hist_reg [LEN-1];
    logic [FW-1:0]     fill_reg;
    logic              flag_reg;
    logic              armed_reg;
    logic [CW-1:0]     cnt_reg;

    logic [LEN-1:0]    sym_eq;
    logic              accept;
    logic              match;

    // Per-symbol equality: history slots against pattern symbols 0..LEN-2
    for (genvar gi = 0; gi < LEN - 1; gi++) begin : g_hist_cmp
        assign sym_eq[gi] = (hist_reg[gi] == pat_reg[gi*DW +: DW]);
    end
    assign sym_eq[LEN-1] = (bus.data_i == pat_reg[(LEN-1)*DW +: DW]);

    // Symbols arriving with a config load are discarded, as are stalls
    assign accept = (state_reg == RUN) && bus.valid_i && !bus.cfg_load;
    assign match  = accept && (fill_reg == FILL_MAX) && (&sym_eq);

    // Controller, history shifter, match flag and counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            pat_reg   <= '0;
            ovl_reg   <= 1'b0;
            fill_reg  <= '0;
            flag_reg  <= 1'b0;
            armed_reg <= 1'b0;
            cnt_reg   <= '0;
            for (int i = 0; i < LEN - 1; i++) begin
                hist_reg[i] <= '0;
            end
        end else begin
            flag_reg <= 1'b0;
            if (bus.cfg_load) begin
                state_reg <= RUN;
                armed_reg <= 1'b1;
                pat_reg   <= bus.pat_i;
                ovl_reg   <= bus.ovl_i;
                fill_reg  <= '0;
                cnt_reg   <= '0;
            end else begin
                if (accept) begin
                    flag_reg <= match;
                    for (int i = 0; i < LEN - 2; i++) begin
                        hist_reg[i] <= hist_reg[i+1];
                    end
                    hist_reg[LEN-2] <= bus.data_i;
                    // Non-overlap mode restarts the fill so the next match needs LEN fresh symbols
                    if (match && !ovl_reg) begin
                        fill_reg <= '0;
                    end else if (fill_reg != FILL_MAX) begin
                        fill_reg <= fill_reg + 1'b1;
                    end
                end
                // Clear wins over a coincident match increment
                if (bus.cnt_clr) begin
                    cnt_reg <= '0;
                end else if (match && (cnt_reg != CNT_MAX)) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    end

    assign bus.armed_o = armed_reg;
    assign bus.flag_o  = flag_reg;
    assign bus.cnt_o   = cnt_reg;
endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench for seq_detect_param: a default LEN=3/CW=16 instance and a
// LEN=2/CW=2 instance for counter saturation. Table rows carry explicit expectations,
// queued when driven and compared one cycle later.
module tb_seq_detect_param;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_detect_param_if #(.DW(8), .LEN(3), .CW(16)) bus1 ();
    seq_detect_param_if #(.DW(8), .LEN(2), .CW(2))  bus2 ();

    seq_detect_param #(.DW(8), .LEN(3), .CW(16)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    seq_detect_param #(.DW(8), .LEN(2), .CW(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    typedef struct {
        logic        cfg;
        logic [23:0] pat;
        logic        ovl;
        logic        valid;
        logic [7:0]  data;
        logic        clr;
        logic        e_flag;
        logic [15:0] e_cnt;
        logic        e_armed;
    } vec_t;

    vec_t t1[$];
    vec_t t2[$];
    vec_t exp_q[$];
    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(input logic cfg, input logic [23:0] pat, input logic ovl,
                                input logic valid, input logic [7:0] data, input logic clr,
                                input logic f, input logic [15:0] c, input logic a);
        vec_t v;
        v.cfg = cfg; v.pat = pat; v.ovl = ovl; v.valid = valid; v.data = data;
        v.clr = clr; v.e_flag = f; v.e_cnt = c; v.e_armed = a;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s #%0d: got %0h, expected %0h", name, idx, got, want);
        end
    endtask

    task automatic idle_all();
        bus1.cfg_load = 0; bus1.pat_i = '0; bus1.ovl_i = 0; bus1.valid_i = 0; bus1.data_i = '0; bus1.cnt_clr = 0;
        bus2.cfg_load = 0; bus2.pat_i = '0; bus2.ovl_i = 0; bus2.valid_i = 0; bus2.data_i = '0; bus2.cnt_clr = 0;
    endtask

    task automatic step(input int sel, input vec_t v, input string name, input int idx);
        vec_t e;
        logic        g_flag;
        logic [15:0] g_cnt;
        logic        g_armed;
        @(negedge clk);
        idle_all();
        if (sel == 1) begin
            bus1.cfg_load = v.cfg; bus1.pat_i = v.pat; bus1.ovl_i = v.ovl;
            bus1.valid_i = v.valid; bus1.data_i = v.data; bus1.cnt_clr = v.clr;
        end else begin
            bus2.cfg_load = v.cfg; bus2.pat_i = v.pat[15:0]; bus2.ovl_i = v.ovl;
            bus2.valid_i = v.valid; bus2.data_i = v.data; bus2.cnt_clr = v.clr;
        end
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        if (sel == 1) begin
            g_flag = bus1.flag_o; g_cnt = bus1.cnt_o; g_armed = bus1.armed_o;
        end else begin
            g_flag = bus2.flag_o; g_cnt = {14'd0, bus2.cnt_o}; g_armed = bus2.armed_o;
        end
        $display("%s #%0d: cfg=%0d valid=%0d data=%02h clr=%0d -> flag=%0d cnt=%0d armed=%0d",
                 name, idx, v.cfg, v.valid, v.data, v.clr, g_flag, g_cnt, g_armed);
        chk({name, " flag"},  idx, {31'd0, g_flag},  {31'd0, e.e_flag});
        chk({name, " cnt"},   idx, {16'd0, g_cnt},   {16'd0, e.e_cnt});
        chk({name, " armed"}, idx, {31'd0, g_armed}, {31'd0, e.e_armed});
    endtask

    initial begin
        // Unarmed: stream before any cfg_load is ignored
        t1.push_back(mk(0, 0, 0, 1, 8'hAA, 0, 0, 0, 0));
        t1.push_back(mk(0, 0, 0, 1, 8'hBB, 0, 0, 0, 0));
        t1.push_back(mk(0, 0, 0, 1, 8'hCC, 0, 0, 0, 0));
        // Basic stream, pattern AA,BB,CC overlap
        t1.push_back(mk(1, 24'hCCBBAA, 1, 0, 8'h00, 0, 0, 0, 1));
        t1.push_back(mk(0, 0, 0, 1, 8'hAA, 0, 0, 0, 1));
        t1.push_back(mk(0, 0, 0, 1, 8'hBB, 0, 0, 0, 1));
        t1.push_back(mk(0, 0, 0, 1, 8'hCC, 0, 1, 1, 1));
        t1.push_back(mk(0, 0, 0, 1, 8'hBB, 0, 0, 1, 1));
        t1.push_back(mk(0, 0, 0, 1, 8'hAA, 0, 0, 1, 1));
        t1.push_back(mk(0, 0, 0, 1, 8'hBB, 0, 0, 1, 1));
        t1.push_back(mk(0, 0, 0, 1, 8'hCC, 0, 1, 2, 1));
        t1.push_back(mk(0, 0, 0, 1, 8'hAA, 0, 0, 2, 1));
        t1.push_back(mk(0, 0, 0, 1, 8'hBB, 0, 0, 2, 1));
        t1.push_back(mk(0, 0, 0, 1, 8'hAA, 0, 0, 2, 1));
        t1.push_back(mk(0, 0, 0, 1, 8'hBB, 0, 0, 2, 1));
        t1.push_back(mk(0, 0, 0, 1, 8'hCC, 0, 1, 3, 1));
        t1.push_back(mk(0, 0, 0, 1, 8'hCC, 0, 0, 3, 1));
        // Overlap mode, pattern AA,BB,AA
        t1.push_back(mk(1, 24'hAABBAA, 1, 0, 8'h00, 0, 0, 0, 1));
        t1.push_back(mk(0, 0, 0, 1, 8'hAA, 0, 0, 0, 1));
        t1.push_back(mk(0, 0, 0, 1, 8'hBB, 0, 0, 0, 1));
        t1.push_back(mk(0, 0, 0, 1, 8'hAA, 0, 1, 1, 1));
        t1.push_back(mk(0, 0, 0, 1, 8'hBB, 0, 0, 1, 1));
        t1.push_back(mk(0, 0, 0, 1, 8'hAA, 0, 1, 2, 1));
        // Non-overlap mode, same pattern
        t1.push_back(mk(1, 24'hAABBAA, 0, 0, 8'h00, 0, 0, 0, 1));
        t1.push_back(mk(0, 0, 0, 1, 8'hAA, 0, 0, 0, 1));
        t1.push_back(mk(0, 0, 0, 1, 8'hBB, 0, 0, 0, 1));
        t1.push_back(mk(0, 0, 0, 1, 8'hAA, 0, 1, 1, 1));
        t1.push_back(mk(0, 0, 0, 1, 8'hBB, 0, 0, 1, 1));
        t1.push_back(mk(0, 0, 0, 1, 8'hAA, 0, 0, 1, 1));
        // Stall tolerance: valid_i=0 with FF between BB and CC
        t1.push_back(mk(1, 24'hCCBBAA, 1, 0, 8'h00, 0, 0, 0, 1));
        t1.push_back(mk(0, 0, 0, 1, 8'hAA, 0, 0, 0, 1));
        t1.push_back(mk(0, 0, 0, 1, 8'hBB, 0, 0, 0, 1));
        t1.push_back(mk(0, 0, 0, 0, 8'hFF, 0, 0, 0, 1));
        t1.push_back(mk(0, 0, 0, 0, 8'hFF, 0, 0, 0, 1));
        t1.push_back(mk(0, 0, 0, 0, 8'hFF, 0, 0, 0, 1));
        t1.push_back(mk(0, 0, 0, 1, 8'hCC, 0, 1, 1, 1));
        // Same gap with valid FF symbols breaks the match
        t1.push_back(mk(0, 0, 0, 1, 8'hAA, 0, 0, 1, 1));
        t1.push_back(mk(0, 0, 0, 1, 8'hBB, 0, 0, 1, 1));
        t1.push_back(mk(0, 0, 0, 1, 8'hFF, 0, 0, 1, 1));
        t1.push_back(mk(0, 0, 0, 1, 8'hFF, 0, 0, 1, 1));
        t1.push_back(mk(0, 0, 0, 1, 8'hFF, 0, 0, 1, 1));
        t1.push_back(mk(0, 0, 0, 1, 8'hCC, 0, 0, 1, 1));
        // Reload mid-match after AA BB clears history; data with cfg_load is ignored
        t1.push_back(mk(0, 0, 0, 1, 8'hAA, 0, 0, 1, 1));
        t1.push_back(mk(0, 0, 0, 1, 8'hBB, 0, 0, 1, 1));
        t1.push_back(mk(1, 24'hCCBBAA, 1, 1, 8'hAA, 0, 0, 0, 1));
        t1.push_back(mk(0, 0, 0, 1, 8'hBB, 0, 0, 0, 1));
        t1.push_back(mk(0, 0, 0, 1, 8'hCC, 0, 0, 0, 1));
        // Clear coinciding with a match wins
        t1.push_back(mk(0, 0, 0, 1, 8'hAA, 0, 0, 0, 1));
        t1.push_back(mk(0, 0, 0, 1, 8'hBB, 0, 0, 0, 1));
        t1.push_back(mk(0, 0, 0, 1, 8'hCC, 0, 1, 1, 1));
        t1.push_back(mk(0, 0, 0, 1, 8'hAA, 0, 0, 1, 1));
        t1.push_back(mk(0, 0, 0, 1, 8'hBB, 0, 0, 1, 1));
        t1.push_back(mk(0, 0, 0, 1, 8'hCC, 1, 1, 0, 1));

        // Counter saturation on LEN=2, CW=2 instance, pattern AA,AA
        t2.push_back(mk(1, 24'h00AAAA, 1, 0, 8'h00, 0, 0, 0, 1));
        t2.push_back(mk(0, 0, 0, 1, 8'hAA, 0, 0, 0, 1));
        t2.push_back(mk(0, 0, 0, 1, 8'hAA, 0, 1, 1, 1));
        t2.push_back(mk(0, 0, 0, 1, 8'hAA, 0, 1, 2, 1));
        t2.push_back(mk(0, 0, 0, 1, 8'hAA, 0, 1, 3, 1));
        t2.push_back(mk(0, 0, 0, 1, 8'hAA, 0, 1, 3, 1));
        t2.push_back(mk(0, 0, 0, 1, 8'hAA, 0, 1, 3, 1));
        t2.push_back(mk(0, 0, 0, 1, 8'hAA, 1, 1, 0, 1));
        t2.push_back(mk(0, 0, 0, 1, 8'hAA, 0, 1, 1, 1));

        // Reset and check the reset state of both instances
        idle_all();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("reset flag1",  0, {31'd0, bus1.flag_o},  32'd0);
        chk("reset cnt1",   0, {16'd0, bus1.cnt_o},   32'd0);
        chk("reset armed1", 0, {31'd0, bus1.armed_o}, 32'd0);
        chk("reset cnt2",   0, {30'd0, bus2.cnt_o},   32'd0);
        chk("reset armed2", 0, {31'd0, bus2.armed_o}, 32'd0);

        for (int i = 0; i < t1.size(); i++) step(1, t1[i], "main", i);
        for (int i = 0; i < t2.size(); i++) step(2, t2[i], "sat", i);

        // Asynchronous reset mid-cycle while flag, count and armed are all set
        step(1, mk(0, 0, 0, 1, 8'hAA, 0, 0, 0, 1), "arst", 0);
        step(1, mk(0, 0, 0, 1, 8'hBB, 0, 0, 0, 1), "arst", 1);
        step(1, mk(0, 0, 0, 1, 8'hCC, 0, 1, 1, 1), "arst", 2);
        #2;
        rst_n = 1'b0;
        #1;
        $display("arst #3: rst_n low mid-cycle -> flag=%0d cnt=%0d armed=%0d",
                 bus1.flag_o, bus1.cnt_o, bus1.armed_o);
        chk("arst flag",  3, {31'd0, bus1.flag_o},  32'd0);
        chk("arst cnt",   3, {16'd0, bus1.cnt_o},   32'd0);
        chk("arst armed", 3, {31'd0, bus1.armed_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, mk(0, 0, 0, 1, 8'hCC, 0, 0, 0, 0), "arst", 4);
        // Re-arm after reset: AA BB from a cleared history, CC completes
        step(1, mk(1, 24'hCCBBAA, 1, 0, 8'h00, 0, 0, 0, 1), "arst", 5);
        step(1, mk(0, 0, 0, 1, 8'hCC, 0, 0, 0, 1), "arst", 6);
        step(1, mk(0, 0, 0, 1, 8'hAA, 0, 0, 0, 1), "arst", 7);
        step(1, mk(0, 0, 0, 1, 8'hBB, 0, 0, 0, 1), "arst", 8);
        step(1, mk(0, 0, 0, 1, 8'hCC, 0, 1, 1, 1), "arst", 9);

        idle_all();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
